// File: rtl/regfile_dump_pkg.sv
// Shared debug types for the register-file dump engine.
// Widths here match the CPU register file.
package regfile_dump_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] idx;
    logic [RF_DATA_W-1:0] data;
    logic                 last;
  } beat_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks the register file in address order and streams
// (index, data) beats over a valid/ready port.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = 2**ADDR_W,
  parameter int SKIP_R0  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST =
    (SKIP_R0 != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  state_t            st;
  state_t            nx;
  logic [ADDR_W-1:0] idx;
  logic              xfer;

  assign xfer = (st == SEND) && out_ready;

  always_comb begin
    nx = st;
    case (st)
      IDLE: if (start) nx = READ;
      READ: nx = SEND;
      SEND: if (out_ready) nx = out_last ? DONE : READ;
      DONE: nx = IDLE;
      default: nx = IDLE;
    endcase
    // abort has no meaning while idle, so start wins there
    if (abort && st != IDLE) nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= FIRST;
    end else if (st == IDLE && start) begin
      idx <= FIRST;
    end else if (xfer && !out_last && !abort) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  // Each register is sampled at its own READ edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (st == READ) begin
      out_index <= idx;
      out_data  <= rf_data;
      out_last  <= (idx == LAST);
    end
  end

  always_comb begin
    rf_addr   = (st == READ) ? idx : '0;
    out_valid = (st == SEND);
    busy      = (st != IDLE);
    done      = (st == DONE);
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full walk, backpressure,
// abort, start-while-busy, live writes, SKIP_R0=0, async reset.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        start1 = 1'b0;
  logic [4:0]  rf_addr1;
  logic [31:0] rf_data1;
  logic        out_valid1;
  logic [4:0]  out_index1;
  logic [31:0] out_data1;
  logic        out_last1;
  logic        busy1;
  logic        done1;

  logic [31:0] rf [32];
  beat_t       q[$];
  int          done_cnt = 0;
  int          beats1 = 0;
  int          checks = 0;
  int          errors = 0;

  assign rf_data  = rf[rf_addr];
  assign rf_data1 = rf[rf_addr1];

  always #5 clk = ~clk;

  regfile_dump #(.SKIP_R0(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  regfile_dump #(.SKIP_R0(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .rf_addr(rf_addr1), .rf_data(rf_data1),
    .out_valid(out_valid1), .out_ready(1'b1),
    .out_index(out_index1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1), .done(done1)
  );

  // Beats that will transfer at the coming rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready)
        q.push_back('{idx: out_index, data: out_data,
                      last: out_last});
      if (done) done_cnt++;
      if (out_valid1) beats1++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beat(input logic [4:0] n);
    int k;
    k = 0;
    while (!(out_valid && out_index == n) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("beat_timeout", 64'(n), 64'hFF);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) chk("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int cyc;
    int d0;
    for (int i = 0; i < 32; i++)
      rf[i] = (i == 0) ? 32'h0 : 32'h0101_0101 * i;
    rf[5]  = 32'hDEAD_BEEF;
    rf[31] = 32'h1234_5678;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_addr", 64'(rf_addr), 0);
    chk("rst_data", 64'(out_data), 0);

    // Full walk, ready held high
    q.delete();
    d0 = done_cnt;
    go();
    wait_done(cyc);
    chk("done_lat", 64'(cyc), 62);
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("post_busy", 64'(busy), 0);
    chk("n_beats", 64'(q.size()), 31);
    if (q.size() == 31) begin
      chk("b1_idx", 64'(q[0].idx), 1);
      chk("b5_idx", 64'(q[4].idx), 5);
      chk("b5_data", 64'(q[4].data), 64'hDEAD_BEEF);
      chk("b2_data", 64'(q[1].data), 64'h0202_0202);
      chk("b30_last", 64'(q[29].last), 0);
      chk("b31_idx", 64'(q[30].idx), 31);
      chk("b31_data", 64'(q[30].data), 64'h1234_5678);
      chk("b31_last", 64'(q[30].last), 1);
    end

    // Backpressure on beat 7
    go();
    wait_beat(5'd7);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_idx", 64'(out_index), 7);
      chk("bp_data", 64'(out_data), 64'h0707_0707);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_gap", 64'(out_valid), 0);
    tick();
    chk("bp_next_v", 64'(out_valid), 1);
    chk("bp_next_i", 64'(out_index), 8);
    wait_done(cyc);

    // Abort during beat 10
    d0 = done_cnt;
    go();
    wait_beat(5'd10);
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 64'(out_valid), 0);
    chk("ab_busy", 64'(busy), 0);
    repeat (3) tick();
    chk("ab_nodone", 64'(done_cnt - d0), 0);
    out_ready = 1'b1;
    go();
    tick();
    chk("ab_restart", 64'(out_index), 1);
    chk("ab_rs_v", 64'(out_valid), 1);
    wait_done(cyc);

    // start while busy is ignored
    q.delete();
    go();
    wait_beat(5'd3);
    go();
    wait_done(cyc);
    chk("sb_beats", 64'(q.size()), 31);
    if (q.size() == 31) begin
      chk("sb_b4", 64'(q[3].idx), 4);
      chk("sb_b5", 64'(q[4].idx), 5);
    end

    // Live write lands before r20 is read
    q.delete();
    go();
    wait_beat(5'd12);
    rf[20] = 32'hA5A5_A5A5;
    wait_done(cyc);
    if (q.size() == 31) begin
      chk("wr_idx", 64'(q[19].idx), 20);
      chk("wr_data", 64'(q[19].data), 64'hA5A5_A5A5);
    end else begin
      chk("wr_beats", 64'(q.size()), 31);
    end

    // Walk from r0
    beats1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("s0_valid", 64'(out_valid1), 1);
    chk("s0_idx", 64'(out_index1), 0);
    chk("s0_data", 64'(out_data1), 0);
    cyc = 0;
    while (!done1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("s0_beats", 64'(beats1), 32);

    // Async reset mid-dump
    d0 = done_cnt;
    go();
    repeat (9) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", 64'(busy), 0);
    chk("ar_valid", 64'(out_valid), 0);
    chk("ar_addr", 64'(rf_addr), 0);
    chk("ar_data", 64'(out_data), 0);
    chk("ar_idx", 64'(out_index), 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("ar_nodone", 64'(done_cnt - d0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
